// File: rtl/z80_bus_responder.sv
// z80_bus_responder: tv80s memory/IO responder with a shared byte array and wait states.
// Define Z80BUS_TRACE_EN to build the write-trace FIFO; otherwise trace outputs read as 0.
module z80_bus_responder #(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] IO_PAGE     = 8'h10,
  parameter int         MEM_WAIT    = 0,
  parameter int         IO_WAIT     = 0,
  parameter int         TRACE_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  output logic        cpu_wait_n,
  output logic        trc_valid,
  output logic [24:0] trc_data,
  input  logic        trc_ready,
  output logic        trc_overflow,
  input  logic        trc_clear
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [2:0]        n_wait;
  logic              wait_nx, wait_q;
  logic              committed;
  logic              mem_cyc, io_cyc, active, cyc_end;
  logic              start, commit;
  logic [15:0]       io_addr;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        mem [2**ADDR_W];

  assign mem_cyc = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
  assign io_cyc  = !cpu_iorq_n && cpu_m1_n && (!cpu_rd_n || !cpu_wr_n);
  assign active  = mem_cyc || io_cyc;
  assign cyc_end = cpu_mreq_n && cpu_iorq_n;
  assign start   = active && !committed;
  assign commit  = start && !cpu_wr_n;
  assign io_addr = {IO_PAGE, cpu_a[7:0]};
  assign addr    = cpu_iorq_n ? cpu_a[ADDR_W-1:0] : io_addr[ADDR_W-1:0];
  assign n_wait  = io_cyc ? 3'(IO_WAIT) : 3'(MEM_WAIT);

  // Set on reset so a cycle already in flight at release is never qualified.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   committed <= 1'b1;
    else if (cyc_end) committed <= 1'b0;
    else if (start)   committed <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (commit) mem[addr] <= cpu_do;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cpu_di <= '0;
    else            cpu_di <= mem[addr];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      wait_q <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wait_q <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (n_wait != 3'd0) begin
            state_nx = WAIT;
            cnt_nx   = n_wait - 3'd1;
          end else begin
            state_nx = HOLD;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nx = HOLD;
        else             cnt_nx   = cnt - 3'd1;
      end
      HOLD: begin
        if (cyc_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wait_nx = (state_nx != WAIT);
  end

  assign cpu_wait_n = wait_q;

`ifdef Z80BUS_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);

  logic [24:0] fifo [TRACE_DEPTH];
  logic [PW:0] wp, rp;
  logic        empty, full, push, pop, accept;

  assign empty  = (wp == rp);
  assign full   = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign pop    = trc_valid && trc_ready;
  assign push   = commit && !trc_clear;
  assign accept = push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (accept) fifo[wp[PW-1:0]] <= {!cpu_iorq_n, 16'(addr), cpu_do};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wp           <= '0;
      rp           <= '0;
      trc_overflow <= 1'b0;
    end else if (trc_clear) begin
      wp           <= '0;
      rp           <= '0;
      trc_overflow <= 1'b0;
    end else begin
      if (accept)          wp           <= wp + 1'b1;
      if (pop)             rp           <= rp + 1'b1;
      if (push && !accept) trc_overflow <= 1'b1;
    end
  end

  assign trc_valid = !empty;
  assign trc_data  = empty ? '0 : fifo[rp[PW-1:0]];
`else
  logic unused_trc;
  assign unused_trc   = trc_ready ^ trc_clear;
  assign trc_valid    = 1'b0;
  assign trc_data     = '0;
  assign trc_overflow = 1'b0;
`endif

endmodule
